// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised oversampling UART receiver with majority voting.
// Parity checking is compiled in when UART_RX_CFG_PARITY_EN is defined.
module uart_rx_cfg #(
    parameter int NB_DATA = 8,
    parameter int NB_STOP = 1,
    parameter int OVS     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx,
    input  logic               s_tick,
    input  logic               parity_odd,
    output logic               rx_done_tick,
    output logic [NB_DATA-1:0] data_out,
    output logic               parity_err,
    output logic               frame_err,
    output logic               busy
);
    localparam int CW = $clog2(OVS);
    localparam int BW = $clog2(NB_DATA + 1);
    localparam logic [CW-1:0] T_S0  = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] T_S1  = CW'(OVS / 2);
    localparam logic [CW-1:0] T_S2  = CW'(OVS / 2 + 1);
    localparam logic [CW-1:0] T_END = CW'(OVS - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(NB_DATA - 1);
    localparam logic          LAST_STOP = 1'(NB_STOP - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_CFG_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t             state_q;
    logic               rx_meta_q, rx_s_q;
    logic [CW-1:0]      cnt_q;
    logic [BW-1:0]      bit_idx_q;
    logic               stop_idx_q;
    logic [1:0]         samp_q;
    logic               vote_q;
    logic [NB_DATA-1:0] shift_q;
    logic               frame_q;
    logic               done_q;
    logic [NB_DATA-1:0] data_q;
    logic               ferr_q;
    logic               maj_d;
    logic               counting_d;
    logic               ferr_d;

    always_comb begin
        // Third sample is the live synchronised line at tick OVS/2+1.
        maj_d      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
        counting_d = (state_q != IDLE) && (state_q != WAIT_HIGH);
        ferr_d     = frame_q | ~maj_d;
    end

`ifdef UART_RX_CFG_PARITY_EN
    logic podd_q, perr_int_q, perr_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            podd_q     <= 1'b0;
            perr_int_q <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            if (state_q == IDLE && !rx_s_q)
                perr_int_q <= 1'b0;
            if (state_q == START && s_tick && cnt_q == T_S2 && !maj_d)
                podd_q <= parity_odd;
            if (state_q == PARITY && s_tick && cnt_q == T_END)
                perr_int_q <= vote_q ^ (^shift_q) ^ podd_q;
            if (state_q == STOP && s_tick && cnt_q == T_S2 && stop_idx_q == LAST_STOP)
                perr_q <= perr_int_q;
        end
    end
    assign parity_err = perr_q;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
    assign parity_err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            samp_q     <= 2'b11;
            vote_q     <= 1'b1;
            shift_q    <= '0;
            frame_q    <= 1'b0;
            done_q     <= 1'b0;
            data_q     <= '0;
            ferr_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            done_q    <= 1'b0;
            if (counting_d && s_tick) begin
                cnt_q <= (cnt_q == T_END) ? '0 : cnt_q + 1'b1;
                if (cnt_q == T_S0) samp_q[0] <= rx_s_q;
                if (cnt_q == T_S1) samp_q[1] <= rx_s_q;
                if (cnt_q == T_S2) vote_q    <= maj_d;
            end
            case (state_q)
                IDLE: if (!rx_s_q) begin
                    state_q <= START;
                    cnt_q   <= '0;
                    frame_q <= 1'b0;
                end
                START: if (s_tick) begin
                    if (cnt_q == T_S2 && maj_d)
                        state_q <= IDLE;
                    else if (cnt_q == T_END) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                    end
                end
                DATA: if (s_tick && cnt_q == T_END) begin
                    shift_q   <= {vote_q, shift_q[NB_DATA-1:1]};
                    bit_idx_q <= bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
                        stop_idx_q <= 1'b0;
`ifdef UART_RX_CFG_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= STOP;
`endif
                    end
                end
`ifdef UART_RX_CFG_PARITY_EN
                PARITY: if (s_tick && cnt_q == T_END) begin
                    state_q    <= STOP;
                    stop_idx_q <= 1'b0;
                end
`endif
                STOP: if (s_tick) begin
                    // Final stop bit resolves mid-window so a following start bit is not missed.
                    if (cnt_q == T_S2 && stop_idx_q == LAST_STOP) begin
                        done_q  <= 1'b1;
                        data_q  <= shift_q;
                        ferr_q  <= ferr_d;
                        state_q <= (!ferr_d && rx_s_q) ? IDLE : WAIT_HIGH;
                    end else if (cnt_q == T_S2 && !maj_d)
                        frame_q <= 1'b1;
                    else if (cnt_q == T_END)
                        stop_idx_q <= stop_idx_q + 1'b1;
                end
                WAIT_HIGH: if (rx_s_q) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_done_tick = done_q;
    assign data_out     = data_q;
    assign frame_err    = ferr_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - frame-level scoreboard bench for uart_rx_cfg (OVS=16, 8 data, 1 stop).
module tb_uart_rx_cfg;
    localparam int OVS = 16;
`ifdef UART_RX_CFG_PARITY_EN
    localparam int NPAR = 2;
`else
    localparam int NPAR = 0;
`endif

    logic       clk = 1'b0;
    logic       reset, rx, s_tick, parity_odd;
    logic       rx_done_tick, parity_err, frame_err, busy;
    logic [7:0] data_out;

    uart_rx_cfg #(.NB_DATA(8), .NB_STOP(1), .OVS(OVS)) dut (
        .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick), .parity_odd(parity_odd),
        .rx_done_tick(rx_done_tick), .data_out(data_out), .parity_err(parity_err),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t expq[$];
    exp_t held = '0;
    int   vectors = 0;
    int   miscompares = 0;
    int   strobes = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Every strobe retires one predicted word; held outputs must match the last retired word.
    always @(posedge clk) begin
        #1;
        if (rx_done_tick === 1'b1) begin
            strobes++;
            if (expq.size() == 0)
                chk("unexpected_strobe", 32'd1, 32'd0);
            else
                held = expq.pop_front();
        end
        chk("data_out", {24'd0, data_out}, {24'd0, held.d});
        chk("parity_err", {31'd0, parity_err}, {31'd0, held.pe});
        chk("frame_err", {31'd0, frame_err}, {31'd0, held.fe});
    end

    task automatic step(input logic v);
        @(negedge clk) rx = v; s_tick = 1'b0;
        @(negedge clk);
        @(negedge clk) s_tick = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1; rx = 1'b1; s_tick = 1'b0;
        held = '0;
        expq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // pmode<0: correct parity bit; glitch_bit: frame bit whose mid-window sample is inverted.
    task automatic send_frame(input logic [7:0] d, input int pmode, input logic stopv,
                              input int glitch_bit, input int abort_bit);
        logic [11:0] bits;
        int          n;
        logic        pb;
        exp_t        e;
        bits = '0;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            bits[n] = d[i];
            n++;
        end
        pb = 1'b0;
`ifdef UART_RX_CFG_PARITY_EN
        pb = (pmode < 0) ? ((^d) ^ parity_odd) : pmode[0];
        bits[n] = pb;
        n++;
`endif
        bits[n] = stopv;
        n++;
        if (abort_bit < 0) begin
            e.d  = d;
            e.fe = ~stopv;
`ifdef UART_RX_CFG_PARITY_EN
            e.pe = pb ^ (^d) ^ parity_odd;
`else
            e.pe = 1'b0;
`endif
            expq.push_back(e);
        end
        for (int b = 0; b < n; b++) begin
            if (b == abort_bit) begin
                do_reset();
                return;
            end
            for (int t = 0; t < OVS; t++)
                step((b == glitch_bit && t == 9) ? ~bits[b] : bits[b]);
        end
    endtask

    initial begin
        reset = 1'b1; rx = 1'b1; s_tick = 1'b0; parity_odd = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_data_out", {24'd0, data_out}, 32'h00);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, rx_done_tick}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        chk("reset_parity_err", {31'd0, parity_err}, 32'd0);
        reset = 1'b0;
        idle(4);

        send_frame(8'hA5, -1, 1'b1, -1, -1);
        idle(8);
        chk("a5_data", {24'd0, data_out}, 32'hA5);
        chk("a5_errs", {30'd0, parity_err, frame_err}, 32'd0);
        chk("a5_busy", {31'd0, busy}, 32'd0);
        chk("a5_strobes", strobes, 32'd1);

`ifdef UART_RX_CFG_PARITY_EN
        parity_odd = 1'b0;
        send_frame(8'h03, 0, 1'b1, -1, -1);
        idle(8);
        chk("par0_err", {31'd0, parity_err}, 32'd0);
        send_frame(8'h03, 1, 1'b1, -1, -1);
        idle(8);
        chk("par1_err", {31'd0, parity_err}, 32'd1);
        chk("par1_data", {24'd0, data_out}, 32'h03);
`endif

        repeat (5) step(1'b0);
        idle(24);
        chk("false_start_busy", {31'd0, busy}, 32'd0);
        chk("false_start_strobes", strobes, 32'(1 + NPAR));
        chk("false_start_data", {24'd0, data_out}, (NPAR != 0) ? 32'h03 : 32'hA5);

        send_frame(8'h5A, -1, 1'b0, -1, -1);
        repeat (48) step(1'b0);
        chk("break_frame_err", {31'd0, frame_err}, 32'd1);
        chk("break_data", {24'd0, data_out}, 32'h5A);
        chk("break_busy", {31'd0, busy}, 32'd1);
        chk("break_strobes", strobes, 32'(2 + NPAR));
        idle(8);
        chk("break_release_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h11, -1, 1'b1, -1, -1);
        idle(8);
        chk("after_break_data", {24'd0, data_out}, 32'h11);
        chk("after_break_frame_err", {31'd0, frame_err}, 32'd0);

        send_frame(8'hFF, -1, 1'b1, 4, -1);
        idle(8);
        chk("glitch_data", {24'd0, data_out}, 32'hFF);

        send_frame(8'h96, -1, 1'b1, -1, 5);
        chk("abort_data", {24'd0, data_out}, 32'h00);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_errs", {30'd0, parity_err, frame_err}, 32'd0);
        idle(8);
        send_frame(8'h3C, -1, 1'b1, -1, -1);
        idle(8);
        chk("post_reset_data", {24'd0, data_out}, 32'h3C);
        chk("total_strobes", strobes, 32'(5 + NPAR));
        chk("pending_words", expq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
